// File: rtl/mc_core.sv
// rtl/mc_core.sv - multicycle MIPS core with wait-state memory handshake
// Optional bne decode is enabled by defining MC_CORE_BNE_EN.
module mc_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          REGS     = 32
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic [3:0]  state,
   output logic        halted
);
   localparam int AW = $clog2(REGS);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11,
      HALT    = 4'd12,
      BNEEX   = 4'd13
   } state_t;

   state_t state_q, state_d;

   logic [31:0] pc_q, ir_q, a_q, b_q, aluout_q, data_q;
   logic [31:0] signimm, alu_y, rd_a, rd_b, rf_wd;
   logic [5:0]  opcode, funct;
   logic [AW-1:0] rs, rt, rd, rf_wa;
   logic        funct_ok, rf_we;
   logic [31:0] rf [REGS];

   assign opcode  = ir_q[31:26];
   assign funct   = ir_q[5:0];
   assign rs      = ir_q[21 +: AW];
   assign rt      = ir_q[16 +: AW];
   assign rd      = ir_q[11 +: AW];
   assign signimm = {{16{ir_q[15]}}, ir_q[15:0]};

   assign rd_a = (rs == '0) ? 32'd0 : rf[rs];
   assign rd_b = (rt == '0) ? 32'd0 : rf[rt];

   // Register file is deliberately left unreset; writes to r0 are dropped.
   always_ff @(posedge clk) begin
      if (rf_we && !reset && rf_wa != '0)
         rf[rf_wa] <= rf_wd;
   end

   always_comb begin
      alu_y    = 32'd0;
      funct_ok = 1'b1;
      case (funct)
         6'h20:   alu_y = a_q + b_q;
         6'h22:   alu_y = a_q - b_q;
         6'h24:   alu_y = a_q & b_q;
         6'h25:   alu_y = a_q | b_q;
         6'h2A:   alu_y = {31'd0, $signed(a_q) < $signed(b_q)};
         default: funct_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= FETCH;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      mem_adr = aluout_q;
      rf_we   = 1'b0;
      rf_wa   = rt;
      rf_wd   = aluout_q;
      case (state_q)
         FETCH: begin
            mem_req = !reset;
            mem_adr = pc_q;
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JEX;
`ifdef MC_CORE_BNE_EN
               OP_BNE:       state_d = BNEEX;
`endif
               default:      state_d = HALT;
            endcase
         end
         MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
         MEMRD: begin
            mem_req = !reset;
            if (mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            rf_we   = 1'b1;
            rf_wd   = data_q;
            state_d = FETCH;
         end
         MEMWR: begin
            mem_req = !reset;
            mem_we  = 1'b1;
            if (mem_ready) state_d = FETCH;
         end
         RTYPEEX: state_d = funct_ok ? RTYPEWB : HALT;
         RTYPEWB: begin
            rf_we   = 1'b1;
            rf_wa   = rd;
            state_d = FETCH;
         end
         BEQEX:   state_d = FETCH;
         ADDIEX:  state_d = ADDIWB;
         ADDIWB: begin
            rf_we   = 1'b1;
            state_d = FETCH;
         end
         JEX:     state_d = FETCH;
`ifdef MC_CORE_BNE_EN
         BNEEX:   state_d = FETCH;
`endif
         default: state_d = HALT;
      endcase
   end

   // DECODE precomputes the branch target so BEQEX/BNEEX only choose it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         ir_q     <= 32'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         aluout_q <= 32'd0;
         data_q   <= 32'd0;
      end else begin
         case (state_q)
            FETCH: begin
               if (mem_ready) begin
                  ir_q <= mem_rdata;
                  pc_q <= pc_q + 32'd4;
               end
            end
            DECODE: begin
               a_q      <= rd_a;
               b_q      <= rd_b;
               aluout_q <= pc_q + {signimm[29:0], 2'b00};
            end
            MEMADR, ADDIEX: aluout_q <= a_q + signimm;
            MEMRD:   if (mem_ready) data_q <= mem_rdata;
            RTYPEEX: if (funct_ok) aluout_q <= alu_y;
            BEQEX:   if (a_q == b_q) pc_q <= aluout_q;
`ifdef MC_CORE_BNE_EN
            BNEEX:   if (a_q != b_q) pc_q <= aluout_q;
`endif
            JEX:     pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
            default: ;
         endcase
      end
   end

   assign mem_wdata = b_q;
   assign pc        = pc_q;
   assign instr     = ir_q;
   assign state     = state_q;
   assign halted    = (state_q == HALT);
endmodule

// File: tb/tb_mc_core.sv
// tb/tb_mc_core.sv - bench for mc_core: directed programs plus random programs vs an ISA model
module tb_mc_core;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req, mem_we, halted;
   logic [31:0] mem_adr, mem_wdata, pc, instr;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_ready = 1'b0;
   logic [3:0]  state;

   mc_core #(.RESET_PC(32'h0000_0100), .REGS(32)) dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
      .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .pc(pc), .instr(instr), .state(state), .halted(halted)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] mem [1024];
   logic [31:0] ref_mem [1024];
   logic [31:0] ref_rf [32];
   int ncyc, n_stall, fixed_stall, waited, want, wr_cycle;
   logic in_acc, acc_we, wr_seen;
   logic [31:0] acc_adr, acc_wd, wr_adr, wr_data;

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction
   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
   endfunction
   function automatic logic [31:0] enc_j(input int target);
      return {6'h02, 26'(target)};
   endfunction

   // One clock of memory service: wait states, bus stability, write capture.
   task automatic cycle();
      @(negedge clk);
      mem_rdata = $urandom;
      if (mem_req) begin
         if (!in_acc) begin
            in_acc = 1'b1; acc_adr = mem_adr; acc_we = mem_we; acc_wd = mem_wdata; waited = 0;
            want = (fixed_stall >= 0) ? fixed_stall : int'($urandom_range(0, 2));
         end else begin
            n_tests++;
            if (mem_adr !== acc_adr || mem_we !== acc_we || mem_wdata !== acc_wd) begin
               n_fail++;
               $display("FAIL bus_stable: adr=%h we=%b wdata=%h, required adr=%h we=%b wdata=%h",
                        mem_adr, mem_we, mem_wdata, acc_adr, acc_we, acc_wd);
            end
         end
         if (waited < want) begin
            mem_ready = 1'b0; waited++; n_stall++;
         end else begin
            mem_ready = 1'b1; in_acc = 1'b0;
            if (mem_we) begin
               mem[mem_adr[11:2]] = mem_wdata;
               wr_seen = 1'b1; wr_cycle = ncyc + 1; wr_adr = mem_adr; wr_data = mem_wdata;
            end else begin
               mem_rdata = mem[mem_adr[11:2]];
            end
         end
      end else begin
         in_acc = 1'b0;
         mem_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      ncyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_acc = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0; ncyc = 0; n_stall = 0; wr_seen = 1'b0;
      #1;
   endtask

   task automatic run_to_halt(input int budget);
      while (!halted && ncyc < budget) cycle();
      n_tests++;
      if (halted !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_timeout: halted=%b after %0d cycles, required 1", halted, ncyc);
      end
   endtask

   // ISA-level interpreter: architectural effect plus cycles-per-instruction.
   task automatic run_model(output int cyc, output logic [31:0] end_pc);
      logic [31:0] p, w, si, x, y, ea, res;
      int rs, rt, rd;
      bit stop, ok;
      p = 32'h100; cyc = 0; stop = 0;
      for (int n = 0; n < 4000 && !stop; n++) begin
         w = ref_mem[p[11:2]];
         rs = int'(w[25:21]); rt = int'(w[20:16]); rd = int'(w[15:11]);
         si = {{16{w[15]}}, w[15:0]};
         x = ref_rf[rs]; y = ref_rf[rt]; ea = x + si;
         p = p + 32'd4;
         case (w[31:26])
            6'h00: begin
               ok = 1; res = 32'd0;
               case (w[5:0])
                  6'h20: res = x + y;
                  6'h22: res = x - y;
                  6'h24: res = x & y;
                  6'h25: res = x | y;
                  6'h2A: res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                  default: ok = 0;
               endcase
               if (ok) begin
                  if (rd != 0) ref_rf[rd] = res;
                  cyc += 4;
               end else begin
                  cyc += 3; stop = 1;
               end
            end
            6'h08: begin if (rt != 0) ref_rf[rt] = ea; cyc += 4; end
            6'h23: begin if (rt != 0) ref_rf[rt] = ref_mem[ea[11:2]]; cyc += 5; end
            6'h2B: begin ref_mem[ea[11:2]] = y; cyc += 4; end
            6'h04: begin if (x == y) p = p + (si << 2); cyc += 3; end
`ifdef MC_CORE_BNE_EN
            6'h05: begin if (x != y) p = p + (si << 2); cyc += 3; end
`endif
            6'h02: begin p = {p[31:28], w[25:0], 2'b00}; cyc += 3; end
            default: begin cyc += 2; stop = 1; end
         endcase
      end
      end_pc = p;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 1024; k++) mem[k] = 32'd0;
      mem[64] = enc_r(0, 0, 1, 6'h20);
      mem[65] = 32'hFC00_0000;
      fixed_stall = 0; in_acc = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (mem_req !== 1'b0 || pc !== 32'h100 || instr !== 32'd0 || state !== 4'd0 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: req=%b pc=%h instr=%h state=%0d halted=%b, required 0 00000100 00000000 0 0",
                  mem_req, pc, instr, state, halted);
      end
      reset = 1'b0; ncyc = 0; n_stall = 0; wr_seen = 1'b0;
      #1;
      n_tests++;
      if (mem_req !== 1'b1 || mem_adr !== 32'h100) begin
         n_fail++;
         $display("FAIL first_fetch: req=%b adr=%h, required 1 00000100", mem_req, mem_adr);
      end
      repeat (4) cycle();
      n_tests++;
      if (mem_adr !== 32'h104 || state !== 4'd0 || mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL rtype_next_fetch: adr=%h state=%0d req=%b, required 00000104 0 1", mem_adr, state, mem_req);
      end
   endtask

   task automatic test_program();
      mem[64] = enc_i(6'h08, 0, 2, 16'd5);
      mem[65] = enc_i(6'h08, 0, 3, 16'd12);
      mem[66] = enc_r(2, 3, 4, 6'h20);
      mem[67] = enc_i(6'h2B, 0, 4, 16'd84);
      mem[68] = 32'hFC00_0000;
      mem[21] = 32'd0;
      fixed_stall = 0;
      do_reset();
      while (!wr_seen && ncyc < 40) cycle();
      n_tests++;
      if (wr_seen !== 1'b1 || wr_cycle != 16 || wr_adr !== 32'h54 || wr_data !== 32'd17) begin
         n_fail++;
         $display("FAIL sw_program: seen=%b cycle=%0d adr=%h data=%0d, required 1 16 00000054 17",
                  wr_seen, wr_cycle, wr_adr, wr_data);
      end
   endtask

   task automatic test_lw_stall();
      mem[64] = enc_i(6'h23, 0, 5, 16'd84);
      mem[65] = enc_i(6'h2B, 0, 5, 16'h60);
      mem[66] = 32'hFC00_0000;
      mem[21] = 32'd17;
      mem[24] = 32'd0;
      fixed_stall = 3;
      do_reset();
      repeat (10) cycle();
      n_tests++;
      if (state !== 4'd4) begin
         n_fail++;
         $display("FAIL lw_stall_wb: state=%0d at cycle 10, required 4", state);
      end
      cycle();
      n_tests++;
      if (state !== 4'd0 || pc !== 32'h104 || mem_adr !== 32'h104) begin
         n_fail++;
         $display("FAIL lw_stall_done: state=%0d pc=%h adr=%h, required 0 00000104 00000104", state, pc, mem_adr);
      end
      run_to_halt(200);
      n_tests++;
      if (mem[24] !== 32'd17 || wr_cycle != 21) begin
         n_fail++;
         $display("FAIL lw_value: stored=%0d at cycle %0d, required 17 at 21", mem[24], wr_cycle);
      end
   endtask

   task automatic test_branch_jump();
      fixed_stall = 0;
      mem[64] = enc_i(6'h04, 2, 2, 16'hFFFF);
      do_reset();
      for (int r = 0; r < 2; r++) begin
         repeat (3) cycle();
         n_tests++;
         if (pc !== 32'h100 || state !== 4'd0 || mem_adr !== 32'h100) begin
            n_fail++;
            $display("FAIL beq_loop: pc=%h state=%0d adr=%h, required 00000100 0 00000100", pc, state, mem_adr);
         end
      end
      mem[64] = enc_j(32'h50);
      mem[80] = enc_j(32'h40);
      do_reset();
      repeat (3) cycle();
      n_tests++;
      if (pc !== 32'h140 || mem_adr !== 32'h140) begin
         n_fail++;
         $display("FAIL jump_fwd: pc=%h adr=%h, required 00000140", pc, mem_adr);
      end
      repeat (3) cycle();
      n_tests++;
      if (pc !== 32'h100 || mem_adr !== 32'h100) begin
         n_fail++;
         $display("FAIL jump_0x40: pc=%h adr=%h, required 00000100", pc, mem_adr);
      end
   endtask

   task automatic test_halt();
      fixed_stall = -1;
      mem[64] = 32'hFC00_0000;
      do_reset();
      run_to_halt(40);
      n_tests++;
      if (ncyc != 2 + n_stall || state !== 4'd12 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_opcode: cycles=%0d state=%0d req=%b, required %0d 12 0", ncyc, state, mem_req, 2 + n_stall);
      end
      repeat (5) cycle();
      n_tests++;
      if (state !== 4'd12 || halted !== 1'b1 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_absorb: state=%0d halted=%b req=%b, required 12 1 0", state, halted, mem_req);
      end
      mem[64] = enc_i(6'h08, 0, 7, 16'd9);
      mem[65] = enc_r(0, 0, 7, 6'h03);
      do_reset();
      n_tests++;
      if (state !== 4'd0 || halted !== 1'b0 || mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_recover: state=%0d halted=%b req=%b, required 0 0 1", state, halted, mem_req);
      end
      run_to_halt(60);
      n_tests++;
      if (ncyc != 7 + n_stall || state !== 4'd12) begin
         n_fail++;
         $display("FAIL halt_funct: cycles=%0d state=%0d, required %0d 12", ncyc, state, 7 + n_stall);
      end
      mem[64] = enc_i(6'h2B, 0, 7, 16'h200);
      mem[65] = 32'hFC00_0000;
      mem[128] = 32'd0;
      do_reset();
      run_to_halt(60);
      n_tests++;
      if (mem[128] !== 32'd9) begin
         n_fail++;
         $display("FAIL halt_no_write: r7=%0d, required 9", mem[128]);
      end
   endtask

   task automatic test_bne();
      fixed_stall = 0;
      mem[64] = enc_i(6'h08, 0, 2, 16'd1);
      mem[65] = enc_i(6'h08, 0, 3, 16'd2);
      mem[66] = enc_i(6'h05, 2, 3, 16'd2);
      mem[67] = 32'hFC00_0000;
      mem[68] = 32'hFC00_0000;
      mem[69] = 32'hFC00_0000;
      do_reset();
      run_to_halt(80);
`ifdef MC_CORE_BNE_EN
      n_tests++;
      if (pc !== 32'h118 || ncyc != 13) begin
         n_fail++;
         $display("FAIL bne_taken: pc=%h cycles=%0d, required 00000118 13", pc, ncyc);
      end
`else
      n_tests++;
      if (pc !== 32'h10C || ncyc != 10 || state !== 4'd12) begin
         n_fail++;
         $display("FAIL bne_halts: pc=%h cycles=%0d state=%0d, required 0000010c 10 12", pc, ncyc, state);
      end
`endif
   endtask

   task automatic test_random_programs();
      logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      int exp_cyc, off, rs, i;
      logic [31:0] exp_pc;
      for (int it = 0; it < 5; it++) begin
         for (int k = 0; k < 1024; k++) mem[k] = 32'd0;
         for (int k = 128; k < 152; k++) mem[k] = $urandom;
         for (int r = 1; r < 8; r++) mem[64 + r - 1] = enc_i(6'h08, 0, r, 16'($urandom));
         for (i = 7; i < 32; i++) begin
            rs = int'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
               0, 1: mem[64 + i] = enc_i(6'h08, rs, int'($urandom_range(0, 7)), 16'($urandom));
               2, 3: mem[64 + i] = enc_r(rs, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                         fns[$urandom_range(0, 4)]);
               4: mem[64 + i] = enc_i(6'h2B, 0, rs, 16'(32'h200 + 4 * $urandom_range(0, 15)));
               5: mem[64 + i] = enc_i(6'h23, 0, rs, 16'(32'h200 + 4 * $urandom_range(0, 15)));
               6: begin
                  off = int'($urandom_range(0, 2));
                  mem[64 + i] = enc_i(6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : int'($urandom_range(0, 7)), 16'(off));
               end
               default: begin
                  off = int'($urandom_range(0, 2));
                  mem[64 + i] = enc_j((32'h100 + 4 * (i + 1 + off)) >> 2);
               end
            endcase
         end
         for (int r = 1; r < 8; r++) mem[64 + 32 + r - 1] = enc_i(6'h2B, 0, r, 16'(32'h240 + 4 * (r - 1)));
         mem[64 + 39] = ($urandom_range(0, 1) == 1) ? 32'hFC00_0000 : enc_r(1, 2, 3, 6'h03);
         for (int k = 0; k < 1024; k++) ref_mem[k] = mem[k];
         for (int r = 0; r < 32; r++) ref_rf[r] = 32'd0;
         run_model(exp_cyc, exp_pc);
         fixed_stall = -1;
         do_reset();
         run_to_halt(4000);
         n_tests++;
         if (pc !== exp_pc || ncyc != exp_cyc + n_stall || state !== 4'd12) begin
            n_fail++;
            $display("FAIL rand_end[%0d]: pc=%h cycles=%0d state=%0d, required %h %0d 12",
                     it, pc, ncyc, state, exp_pc, exp_cyc + n_stall);
         end
         for (int k = 128; k < 152; k++) begin
            n_tests++;
            if (mem[k] !== ref_mem[k]) begin
               n_fail++;
               $display("FAIL rand_mem[%0d] @%h: got %h, required %h", it, k * 4, mem[k], ref_mem[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_program();
      test_lw_stall();
      test_branch_jump();
      test_halt();
      test_bne();
      test_random_programs();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/mc_core.md
# mc_core

Parametrised multicycle MIPS core: shared-bus datapath plus main control FSM in one block, with a wait-state memory handshake. Supersedes the fixed-timing datapath/controller pair: memory may stall any access, the reset PC is configurable, `addi` and `j` are native, and illegal encodings halt cleanly. Sits between the top-level and a single unified instruction/data memory.

## Interface
**Parameters**
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `REGS`, default `32`: register-file depth (power of two, 8..32). Register specifiers are truncated to `$clog2(REGS)` bits.

**Ports**
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `mem_req`, out, 1: memory access request.
- `mem_we`, out, 1: write enable; valid while `mem_req` is high.
- `mem_adr`, out, 32: byte address.
- `mem_wdata`, out, 32: store data.
- `mem_rdata`, in, 32: load or fetch data; valid when `mem_ready` is high.
- `mem_ready`, in, 1: access completes on the edge where `mem_req & mem_ready`.
- `pc`, out, 32: architectural PC.
- `instr`, out, 32: instruction register.
- `state`, out, 4: FSM state code, for debug.
- `halted`, out, 1: core stopped on an illegal opcode or funct.

## Operation
- States and codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, HALT=12.
- FETCH: `mem_req=1`, `mem_we=0`, `mem_adr=pc`. The state holds while `mem_ready=0`. On ready: IR <= `mem_rdata`, PC <= PC+4, go to DECODE.
- DECODE: A and B <= rf[rs] and rf[rt]. ALUOut <= PC + (signimm<<2). Dispatch on opcode:
  - lw (0x23) or sw (0x2B) -> MEMADR
  - R-type (0x00) -> RTYPEEX
  - beq (0x04) -> BEQEX
  - addi (0x08) -> ADDIEX
  - j (0x02) -> JEX
  - anything else -> HALT
- MEMADR: ALUOut <= A + signimm. lw goes to MEMRD, sw goes to MEMWR.
- MEMRD: `mem_req=1`, `mem_adr=ALUOut`. Holds until ready, capturing Data <= `mem_rdata` on the ready edge, then MEMWB.
- MEMWB: rf[rt] <= Data, then FETCH.
- MEMWR: `mem_req=1`, `mem_we=1`, `mem_adr=ALUOut`, `mem_wdata=B`. Holds until ready, then FETCH.
- RTYPEEX: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed). Result goes to ALUOut, then RTYPEWB. Any other funct -> HALT, with no register write.
- RTYPEWB: rf[rd] <= ALUOut, then FETCH.
- BEQEX: compute A−B. If zero, PC <= ALUOut (branch target). Then FETCH.
- ADDIEX: ALUOut <= A + signimm, then ADDIWB. ADDIWB: rf[rt] <= ALUOut, then FETCH.
- JEX: PC <= {PC[31:28], instr[25:0], 2'b00}, then FETCH.
- HALT: absorbing state. `halted=1` and `mem_req=0` until reset.
- Register 0 always reads 0; writes to register 0 are discarded.
- Arithmetic is 32-bit two's complement with wrap and no overflow trap. The immediate is sign-extended from 16 bits.
- `mem_adr`, `mem_we` and `mem_wdata` stay stable for every cycle `mem_req` is high.

## Timing
- Reset values:
  - `pc=RESET_PC`, `instr=0`, `state=0`, `halted=0`
  - A, B, ALUOut and Data all 0
  - Register-file contents are not reset.
- `mem_req` is combinationally gated by `reset`, so it is 0 while reset is high. It is 1 in the first cycle after reset deasserts.
- Cycles per instruction with `mem_ready` tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each low cycle of `mem_ready` during FETCH, MEMRD or MEMWR adds exactly one cycle.
- Register writes take effect at the end of the WB-state edge. A read in the next DECODE sees the new value.
- Reset asserted mid-access: the FSM returns to FETCH immediately and no register or PC update completes. The memory must tolerate an abandoned request.
- `mem_ready` high outside a request is ignored.

## Configuration
- `MC_CORE_BNE_EN`:
  - Defined: opcode 0x05 (bne) decodes to BEQEX-class state BNEEX=13. It takes the branch when A−B is nonzero; same 3-cycle timing as beq.
  - Undefined: opcode 0x05 goes to HALT.

## Test plan
- Reset with `RESET_PC=32'h0000_0100`, ready tied high -> first `mem_adr=0x100`, `mem_req=1`. Next fetch is at 0x104 four cycles after an R-type.
- Load `addi $2,$0,5; addi $3,$0,12; add $4,$2,$3; sw $4,84($0)` -> write at `mem_adr=0x54` with `mem_wdata=17`. Total 16 cycles, ready high throughout.
- `lw $5,84($0)` with `mem_ready` low for 3 cycles in both FETCH and MEMRD -> $5=17, instruction takes 11 cycles, `mem_adr` stable throughout.
- `beq $2,$2,-1` -> PC is unchanged after 3 cycles (loops forever). `j 0x40` -> next `mem_adr=0x100`.
- Opcode 0x3F, or R-type funct 0x03 -> `state=12`, `halted=1`, `mem_req=0`, no register write. Asserting reset then recovers to FETCH.
- `bne $2,$3,+2` with $2≠$3 -> target taken when `MC_CORE_BNE_EN` is defined; `halted=1` when it is not.
